// File: rtl/decode_pkg.sv
// Shared opcode constants and the default-width instruction field layout
// for the decode stage and its scoreboard.
package decode_pkg;

  localparam logic [2:0] OP_NOP     = 3'b111;
  localparam logic [2:0] OP_ILLEGAL = 3'b110;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_REG_ADDR_W = 2;

  typedef struct packed {
    logic [2:0]                alu_op;
    logic [DEF_REG_ADDR_W-1:0] dst;
    logic [DEF_REG_ADDR_W-1:0] src2;
    logic                      imm_sel;
    logic [DEF_DATA_W-1:0]     imm;
  } instr_t;

endpackage

// File: rtl/decode_scoreboard.sv
// Register pending-write scoreboard: one busy bit per register, set by an
// issuing writer and cleared by writeback; a same-cycle set beats a clear.
module decode_scoreboard #(
  parameter int ADDR_W = 2,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/decode_stage.sv
// Single-cycle instruction decode with valid/ready handshake and a register
// scoreboard for RAW hazards. Optional macro: DECODE_ILLEGAL_TRAP_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int REG_ADDR_W = 2,
  localparam int INSTR_W    = 4 + 2*REG_ADDR_W + DATA_W,
  localparam int NREGS      = 2**REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  we,
  output logic [2:0]            alu_op,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [REG_ADDR_W-1:0] read_addr1,
  output logic [REG_ADDR_W-1:0] read_addr2,
  output logic                  immediate_select,
  output logic [DATA_W-1:0]     immediate,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic [NREGS-1:0]      busy_regs,
  output logic                  illegal
);

  logic [2:0]            op_d;
  logic [REG_ADDR_W-1:0] dst_d;
  logic [REG_ADDR_W-1:0] src2_d;
  logic                  sel_d;
  logic [DATA_W-1:0]     imm_d;
  logic                  we_d;
  logic                  hazard;
  logic                  fire;
  logic                  is_illegal;
  logic                  issue;

  assign op_d   = instr[INSTR_W-1 -: 3];
  assign dst_d  = instr[INSTR_W-4 -: REG_ADDR_W];
  assign src2_d = instr[DATA_W+REG_ADDR_W -: REG_ADDR_W];
  assign sel_d  = instr[DATA_W];
  assign imm_d  = instr[DATA_W-1:0];
  assign we_d   = (op_d != OP_NOP);

  // Source A is always the destination register.
  assign hazard   = busy_regs[dst_d] | (!sel_d & busy_regs[src2_d]);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign fire     = in_valid && in_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign is_illegal = (op_d == OP_ILLEGAL);
`else
  assign is_illegal = 1'b0;
`endif

  assign issue = fire && !is_illegal;

  decode_scoreboard #(
    .ADDR_W (REG_ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue && we_d),
    .set_addr (dst_d),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .busy     (busy_regs)
  );

  // Stage p1: registered decoded bundle
  logic                  vld_p1;
  logic                  we_p1;
  logic [2:0]            op_p1;
  logic [REG_ADDR_W-1:0] dst_p1;
  logic [REG_ADDR_W-1:0] src2_p1;
  logic                  sel_p1;
  logic [DATA_W-1:0]     imm_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      op_p1   <= '0;
      dst_p1  <= '0;
      src2_p1 <= '0;
      sel_p1  <= 1'b0;
      imm_p1  <= '0;
    end else if (issue) begin
      vld_p1  <= 1'b1;
      we_p1   <= we_d;
      op_p1   <= op_d;
      dst_p1  <= dst_d;
      src2_p1 <= src2_d;
      sel_p1  <= sel_d;
      imm_p1  <= imm_d;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid        = vld_p1;
  assign we               = we_p1;
  assign alu_op           = op_p1;
  assign write_addr       = dst_p1;
  assign read_addr1       = dst_p1;
  assign read_addr2       = src2_p1;
  assign immediate_select = sel_p1;
  assign immediate        = imm_p1;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 illegal_p1 <= 1'b0;
    else if (fire & is_illegal) illegal_p1 <= 1'b1;
  end

  assign illegal = illegal_p1;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for the steady-state
// pipeline plus hand sequences for hazard, backpressure, trap and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        we;
  logic [2:0]  alu_op;
  logic [1:0]  write_addr;
  logic [1:0]  read_addr1;
  logic [1:0]  read_addr2;
  logic        immediate_select;
  logic [7:0]  immediate;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [3:0]  busy_regs;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instr            (instr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .we               (we),
    .alu_op           (alu_op),
    .write_addr       (write_addr),
    .read_addr1       (read_addr1),
    .read_addr2       (read_addr2),
    .immediate_select (immediate_select),
    .immediate        (immediate),
    .wb_valid         (wb_valid),
    .wb_addr          (wb_addr),
    .busy_regs        (busy_regs),
    .illegal          (illegal)
  );

  typedef struct {
    logic [15:0] instr;
    logic        in_valid;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic        exp_rdy;
    logic        exp_ov;
    logic [2:0]  exp_op;
    logic        exp_we;
    logic [1:0]  exp_wa;
    logic [1:0]  exp_ra2;
    logic        exp_sel;
    logic [7:0]  exp_imm;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] dst,
                                     input logic [1:0] src2, input logic sel,
                                     input logic [7:0] imm);
    return {op, dst, src2, sel, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = 2'd0; instr = 16'h0000;

    //                instr                   iv  wb  wa    rdy ov  op  we  wa   ra2  sel imm     busy
    vecs[0] = '{16'h2B05,                   1, 0, 2'd0, 1, 1, 1, 1, 2'd1, 2'd1, 1, 8'h05, 4'b0010};
    vecs[1] = '{mk(3'd2,2'd2,2'd0,1,8'hAA), 1, 0, 2'd0, 1, 1, 2, 1, 2'd2, 2'd0, 1, 8'hAA, 4'b0110};
    vecs[2] = '{mk(3'd7,2'd3,2'd0,1,8'h11), 1, 0, 2'd0, 1, 1, 7, 0, 2'd3, 2'd0, 1, 8'h11, 4'b0110};
    vecs[3] = '{mk(3'd3,2'd0,2'd1,0,8'h33), 1, 1, 2'd1, 0, 0, 7, 0, 2'd3, 2'd0, 1, 8'h11, 4'b0100};
    vecs[4] = '{mk(3'd3,2'd0,2'd1,0,8'h33), 1, 0, 2'd0, 1, 1, 3, 1, 2'd0, 2'd1, 0, 8'h33, 4'b0101};
    vecs[5] = '{mk(3'd0,2'd3,2'd3,0,8'h00), 0, 1, 2'd3, 1, 0, 3, 1, 2'd0, 2'd1, 0, 8'h33, 4'b0101};
    vecs[6] = '{mk(3'd0,2'd3,2'd3,0,8'h00), 0, 1, 2'd2, 1, 0, 3, 1, 2'd0, 2'd1, 0, 8'h33, 4'b0001};
    vecs[7] = '{mk(3'd4,2'd2,2'd3,1,8'h44), 1, 1, 2'd2, 1, 1, 4, 1, 2'd2, 2'd3, 1, 8'h44, 4'b0101};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy_regs), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_imm", 32'(immediate), 0);
    chk("rst_we", 32'(we), 0);

    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      instr    = vecs[i].instr;
      in_valid = vecs[i].in_valid;
      wb_valid = vecs[i].wb_valid;
      wb_addr  = vecs[i].wb_addr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].exp_op));
      chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_write_addr", i), 32'(write_addr), 32'(vecs[i].exp_wa));
      chk($sformatf("v%0d_read_addr1", i), 32'(read_addr1), 32'(vecs[i].exp_wa));
      chk($sformatf("v%0d_read_addr2", i), 32'(read_addr2), 32'(vecs[i].exp_ra2));
      chk($sformatf("v%0d_imm_sel", i), 32'(immediate_select), 32'(vecs[i].exp_sel));
      chk($sformatf("v%0d_imm", i), 32'(immediate), 32'(vecs[i].exp_imm));
      chk($sformatf("v%0d_busy", i), 32'(busy_regs), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 0);
    end
    wb_valid = 1'b0;

    // RAW hazard on r2 until one cycle after its writeback
    instr = mk(3'd5, 2'd2, 2'd0, 1'b1, 8'h55); in_valid = 1'b1;
    #1;
    chk("raw_blocked0", 32'(in_ready), 0);
    tick();
    chk("raw_drained", 32'(out_valid), 0);
    chk("raw_blocked1", 32'(in_ready), 0);
    wb_valid = 1'b1; wb_addr = 2'd2;
    #1;
    chk("raw_blocked_wb_cycle", 32'(in_ready), 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_released", 32'(in_ready), 1);
    tick();
    chk("raw_accept_valid", 32'(out_valid), 1);
    chk("raw_accept_op", 32'(alu_op), 5);
    chk("raw_accept_busy", 32'(busy_regs), 32'b0101);

    // Backpressure for three cycles, then exactly one handshake
    out_ready = 1'b0;
    instr = mk(3'd1, 2'd3, 2'd0, 1'b1, 8'h13);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 0);
      tick();
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
      chk($sformatf("bp%0d_op", c), 32'(alu_op), 5);
      chk($sformatf("bp%0d_imm", c), 32'(immediate), 32'h55);
      chk($sformatf("bp%0d_wa", c), 32'(write_addr), 2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_op", 32'(alu_op), 1);
    chk("bp_new_imm", 32'(immediate), 32'h13);
    chk("bp_new_busy", 32'(busy_regs), 32'b1101);
    tick();
    chk("bp_single_handshake", 32'(out_valid), 0);
    chk("bp_busy_after", 32'(busy_regs), 32'b1101);

    // Opcode 3'b110 with and without the trap
    out_ready = 1'b0;
    instr = mk(3'd6, 2'd1, 2'd0, 1'b1, 8'h66); in_valid = 1'b1;
    #1;
    chk("op6_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("trap_no_valid", 32'(out_valid), 0);
    chk("trap_illegal", 32'(illegal), 1);
    chk("trap_busy", 32'(busy_regs), 32'b1101);
    tick();
    chk("trap_sticky", 32'(illegal), 1);
    instr = mk(3'd1, 2'd1, 2'd0, 1'b1, 8'h77); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`else
    chk("op6_valid", 32'(out_valid), 1);
    chk("op6_we", 32'(we), 1);
    chk("op6_op", 32'(alu_op), 6);
    chk("op6_illegal", 32'(illegal), 0);
`endif
    chk("pre_rst_busy", 32'(busy_regs), 32'b1111);
    chk("pre_rst_valid", 32'(out_valid), 1);

    // Asynchronous reset mid-transfer
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy_regs), 0);
    chk("arst_illegal", 32'(illegal), 0);
    chk("arst_op", 32'(alu_op), 0);
    chk("arst_imm", 32'(immediate), 0);
    chk("arst_we", 32'(we), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    instr = mk(3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    tick();
    chk("post_rst_valid", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
